// File: rtl/bcd_seg_display.sv
// bcd_seg_display: serial double-dabble binary-to-BCD converter driving a
// 3-digit multiplexed seven-segment display with optional leading-zero blanking.
module bcd_seg_display #(
   parameter int REFRESH_DIV    = 1024,
   parameter bit BLANK_LZ       = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] value,
   input  logic       value_valid,
   output logic [6:0] seg,
   output logic [2:0] digit_sel,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
   localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic [2:0] SEL_OFF = {3{SEG_ACTIVE_LOW}};
   state_t      state_q, state_d;
   logic [7:0]  shreg_q, shreg_d, pend_val_q, pend_val_d;
   logic [11:0] bcd_q, bcd_d, disp_q, disp_d, adj;
   logic [2:0]  cnt_q, cnt_d, sel_q, sel_d;
   logic        pend_q, pend_d, wrap, blank;
   logic [15:0] ref_q, ref_d;
   logic [1:0]  idx_q, idx_d;
   logic [6:0]  seg_q, seg_d, pat;
   logic [3:0]  nib;

   assign adj = {bcd_q[11:8] >= 4'd5 ? bcd_q[11:8] + 4'd3 : bcd_q[11:8],
                 bcd_q[7:4]  >= 4'd5 ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4],
                 bcd_q[3:0]  >= 4'd5 ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0]};

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      disp_d     = disp_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      if (ena) begin
         case (state_q)
            IDLE: if (value_valid) begin
               shreg_d = value;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
            SHIFT: begin
               {bcd_d, shreg_d} = {adj, shreg_q} << 1;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_d = COMMIT;
               if (value_valid) begin
                  pend_d     = 1'b1;
                  pend_val_d = value;
               end
            end
            COMMIT: begin
               disp_d = bcd_q;
               // a strobe arriving now is newer than anything already pending
               if (value_valid || pend_q) begin
                  shreg_d = value_valid ? value : pend_val_q;
                  bcd_d   = '0;
                  cnt_d   = '0;
                  pend_d  = 1'b0;
                  state_d = SHIFT;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign wrap = ref_q == 16'(REFRESH_DIV - 1);

   always_comb begin
      ref_d = ref_q;
      idx_d = idx_q;
      if (ena) begin
         ref_d = wrap ? 16'd0 : ref_q + 16'd1;
         idx_d = !wrap ? idx_q : (idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1);
      end
   end

   assign nib   = idx_q == 2'd2 ? disp_q[11:8] : idx_q == 2'd1 ? disp_q[7:4] : disp_q[3:0];
   assign blank = BLANK_LZ && disp_q[11:8] == 4'd0 &&
                  (idx_q == 2'd2 || (idx_q == 2'd1 && disp_q[7:4] == 4'd0));

   always_comb begin
      case (nib)
         4'd0:    pat = 7'h3F;
         4'd1:    pat = 7'h06;
         4'd2:    pat = 7'h5B;
         4'd3:    pat = 7'h4F;
         4'd4:    pat = 7'h66;
         4'd5:    pat = 7'h6D;
         4'd6:    pat = 7'h7D;
         4'd7:    pat = 7'h07;
         4'd8:    pat = 7'h7F;
         4'd9:    pat = 7'h6F;
         default: pat = 7'h00;
      endcase
   end

   assign seg_d = (ena && !blank ? pat : 7'h00) ^ SEG_OFF;
   assign sel_d = (ena ? 3'b001 << idx_q : 3'b000) ^ SEL_OFF;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         disp_q     <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         ref_q      <= '0;
         idx_q      <= '0;
         seg_q      <= SEG_OFF;
         sel_q      <= SEL_OFF;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         disp_q     <= disp_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         ref_q      <= ref_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         sel_q      <= sel_d;
      end
   end

   assign seg       = seg_q;
   assign digit_sel = sel_q;
   assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_bcd_seg_display.sv
// tb_bcd_seg_display: directed-vector bench for bcd_seg_display, with an
// active-high and an active-low instance sharing the same stimulus.
module tb_bcd_seg_display;
   logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, value_valid = 1'b0;
   logic [7:0] value = 8'd0;
   logic [6:0] seg, seg2;
   logic [2:0] sel, sel2;
   logic       busy, busy2;
   int         vecs = 0, errs = 0;

   always #5 clk = ~clk;

   bcd_seg_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .value(value), .value_valid(value_valid),
      .seg(seg), .digit_sel(sel), .busy(busy));

   bcd_seg_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut2 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .value(value), .value_valid(value_valid),
      .seg(seg2), .digit_sel(sel2), .busy(busy2));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_sel(input logic [2:0] tgt, input bit alt, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
         ok = alt ? (sel2 === ~tgt) : (sel === tgt);
         if (!ok) step();
      end
   endtask

   task automatic convert(input logic [7:0] v, output bit ok);
      value = v;
      value_valid = 1'b1;
      step();
      value_valid = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
         ok = !busy;
         step();
      end
   endtask

   task automatic test_reset();
      step();
      step();
      vecs++;
      if (seg !== 7'h00 || sel !== 3'b000 || busy !== 1'b0) begin
         errs++;
         $display("FAIL reset_hi: seg=%h sel=%b busy=%b, want 00 000 0", seg, sel, busy);
      end
      vecs++;
      if (seg2 !== 7'h7F || sel2 !== 3'b111) begin
         errs++;
         $display("FAIL reset_lo: seg=%h sel=%b, want 7f 111", seg2, sel2);
      end
   endtask

   task automatic test_refresh();
      logic [2:0] es;
      logic [6:0] eg;
      rst_n = 1'b1;
      ena = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         es = k <= 4 ? 3'b001 : k <= 8 ? 3'b010 : 3'b100;
         eg = k <= 4 ? 7'h3F : 7'h00;
         vecs++;
         if (sel !== es || seg !== eg) begin
            errs++;
            $display("FAIL refresh[%0d]: sel=%b seg=%h, want %b %h", k, sel, seg, es, eg);
         end
      end
   endtask

   task automatic test_max();
      int n = 0;
      bit ok;
      logic [2:0] ts[3] = '{3'b100, 3'b010, 3'b001};
      logic [6:0] ex[3] = '{7'h5B, 7'h6D, 7'h6D};
      value = 8'd255;
      value_valid = 1'b1;
      step();
      value_valid = 1'b0;
      while (busy && n < 40) begin
         n++;
         step();
      end
      vecs++;
      if (n !== 9) begin
         errs++;
         $display("FAIL busy_len_255: busy cycles=%0d, want 9", n);
      end
      step();
      for (int d = 0; d < 3; d++) begin
         wait_sel(ts[d], 1'b0, ok);
         vecs++;
         if (!ok || seg !== ex[d]) begin
            errs++;
            $display("FAIL digit_255[%0d]: found=%0d seg=%h, want %h", d, ok, seg, ex[d]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int  bc = 0;
      bit  run = 1'b1, saw7 = 1'b0, saw42 = 1'b0, ok;
      logic [2:0] ts[3] = '{3'b100, 3'b010, 3'b001};
      logic [6:0] ex[3] = '{7'h00, 7'h6F, 7'h6F};
      value = 8'd7;
      value_valid = 1'b1;
      step();
      for (int i = 0; i < 40; i++) begin
         if (run && busy) bc++;
         else run = 1'b0;
         if (sel === 3'b001 && seg === 7'h07) saw7 = 1'b1;
         if ((sel === 3'b001 && seg === 7'h5B) || (sel === 3'b010 && seg === 7'h66)) saw42 = 1'b1;
         value_valid = i == 1 || i == 3;
         if (i == 1) value = 8'd42;
         if (i == 3) value = 8'd99;
         step();
      end
      vecs++;
      if (bc !== 18) begin
         errs++;
         $display("FAIL busy_len_chain: busy cycles=%0d, want 18", bc);
      end
      vecs++;
      if (!saw7) begin
         errs++;
         $display("FAIL show_7: seen=0, want 1");
      end
      vecs++;
      if (saw42) begin
         errs++;
         $display("FAIL hide_42: seen=1, want 0");
      end
      for (int d = 0; d < 3; d++) begin
         wait_sel(ts[d], 1'b0, ok);
         vecs++;
         if (!ok || seg !== ex[d]) begin
            errs++;
            $display("FAIL digit_99[%0d]: found=%0d seg=%h, want %h", d, ok, seg, ex[d]);
         end
      end
   endtask

   task automatic test_blank();
      bit ok;
      logic [2:0] ts[3] = '{3'b100, 3'b010, 3'b001};
      logic [6:0] e100[3] = '{7'h06, 7'h3F, 7'h3F};
      logic [6:0] e5[3] = '{7'h00, 7'h00, 7'h6D};
      convert(8'd100, ok);
      vecs++;
      if (!ok) begin
         errs++;
         $display("FAIL done_100: finished=0, want 1");
      end
      for (int d = 0; d < 3; d++) begin
         wait_sel(ts[d], 1'b0, ok);
         vecs++;
         if (!ok || seg !== e100[d]) begin
            errs++;
            $display("FAIL digit_100[%0d]: found=%0d seg=%h, want %h", d, ok, seg, e100[d]);
         end
      end
      convert(8'd5, ok);
      for (int d = 0; d < 3; d++) begin
         wait_sel(ts[d], 1'b0, ok);
         vecs++;
         if (!ok || seg !== e5[d]) begin
            errs++;
            $display("FAIL digit_5[%0d]: found=%0d seg=%h, want %h", d, ok, seg, e5[d]);
         end
      end
   endtask

   task automatic test_active_low();
      bit ok;
      logic [2:0] ts[3] = '{3'b100, 3'b010, 3'b001};
      logic [6:0] ex[3] = '{7'h7F, 7'h7F, 7'h00};
      convert(8'd8, ok);
      vecs++;
      if (!ok || busy2 !== 1'b0) begin
         errs++;
         $display("FAIL done_lo: finished=%0d busy=%b, want 1 0", ok, busy2);
      end
      for (int d = 0; d < 3; d++) begin
         wait_sel(ts[d], 1'b1, ok);
         vecs++;
         if (!ok || seg2 !== ex[d]) begin
            errs++;
            $display("FAIL digit_lo[%0d]: found=%0d seg=%h, want %h", d, ok, seg2, ex[d]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      value = 8'd200;
      value_valid = 1'b1;
      step();
      value_valid = 1'b0;
      step();
      step();
      step();
      rst_n = 1'b0;
      #1;
      vecs++;
      if (seg !== 7'h00 || sel !== 3'b000 || busy !== 1'b0 || seg2 !== 7'h7F || sel2 !== 3'b111) begin
         errs++;
         $display("FAIL async_rst: seg=%h sel=%b busy=%b seg2=%h sel2=%b, want 00 000 0 7f 111",
                  seg, sel, busy, seg2, sel2);
      end
      step();
      rst_n = 1'b1;
      step();
      vecs++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL rst_busy: busy=%b, want 0", busy);
      end
      wait_sel(3'b001, 1'b0, ok);
      vecs++;
      if (!ok || seg !== 7'h3F) begin
         errs++;
         $display("FAIL rst_ones: found=%0d seg=%h, want 3f", ok, seg);
      end
      wait_sel(3'b010, 1'b0, ok);
      vecs++;
      if (!ok || seg !== 7'h00) begin
         errs++;
         $display("FAIL rst_tens: found=%0d seg=%h, want 00", ok, seg);
      end
   endtask

   task automatic test_ena_off();
      bit ok;
      ena = 1'b0;
      step();
      vecs++;
      if (seg !== 7'h00 || sel !== 3'b000 || seg2 !== 7'h7F || sel2 !== 3'b111) begin
         errs++;
         $display("FAIL ena_off: seg=%h sel=%b seg2=%h sel2=%b, want 00 000 7f 111", seg, sel, seg2, sel2);
      end
      value = 8'd77;
      value_valid = 1'b1;
      step();
      value_valid = 1'b0;
      step();
      vecs++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL ena_strobe: busy=%b, want 0", busy);
      end
      ena = 1'b1;
      step();
      wait_sel(3'b001, 1'b0, ok);
      vecs++;
      if (!ok || seg !== 7'h3F || busy !== 1'b0) begin
         errs++;
         $display("FAIL ena_resume: found=%0d seg=%h busy=%b, want 3f 0", ok, seg, busy);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_refresh();
      test_max();
      test_back_to_back();
      test_blank();
      test_active_low();
      test_reset_mid();
      test_ena_off();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
